// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath:
//   - state_t       : sequencer states of the multi-cycle adder (IDLE/RUN/DONE)
//   - DEFAULT_WIDTH : default operand width
//   - DEFAULT_CHUNK : default bits processed per clock
//   - cnt_width()   : width of a counter that indexes n slices (minimum 1)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder.
// Ports:
//   a, b  : addend bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// ---------------------------------------------------------------------------
// rca_slice
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
// Parameters:
//   CHUNK : slice width in bits
// Ports:
//   a, b  : slice operands
//   ci    : carry into bit 0
//   sum   : slice sum
//   co    : carry out of bit CHUNK-1
//   c_msb : carry into bit CHUNK-1 (used for signed overflow)
// ---------------------------------------------------------------------------
module rca_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  assign carry[0] = ci;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    full_adder u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (carry[gi]),
      .s  (sum[gi]),
      .co (carry[gi+1])
    );
  end

  assign co    = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
// Multi-cycle signed/unsigned add/subtract unit. One CHUNK-bit slice of the
// operands is added per clock through a single rca_slice, LSB slice first.
// Subtraction is A + ~B + 1. Latency from accept to out_valid is
// WIDTH/CHUNK clocks.
//
// Parameters:
//   WIDTH : operand/result width (multiple of CHUNK)
//   CHUNK : bits per clock (1..WIDTH)
// Ports:
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (accepted only in IDLE)
//   in_a, in_b            : operands
//   in_ci                 : carry in (add only)
//   in_sub                : 1 = A - B, 0 = A + B + ci
//   out_valid / out_ready : result handshake
//   out_sum               : result (modulo 2^WIDTH)
//   out_co                : carry out of bit WIDTH-1 (1 = no borrow on sub)
//   out_ovf               : signed overflow
//   out_zero              : result == 0 (only with SEQ_CHUNK_ADDER_ZERO_FLAG_EN)
//
// Build option: define SEQ_CHUNK_ADDER_ZERO_FLAG_EN to add the out_zero port.
// ---------------------------------------------------------------------------
module seq_chunk_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] out_sum_reg;
  logic             out_co_reg;
  logic             out_ovf_reg;

  logic             accept;
  logic             last_slice;

  logic [CHUNK-1:0] slice_sum;
  logic             slice_co;
  logic             slice_c_msb;

  // -------------------------------------------------------------------------
  // Slice adder: always works on the low CHUNK bits of the shift registers.
  // -------------------------------------------------------------------------
  rca_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (a_reg[CHUNK-1:0]),
    .b     (b_reg[CHUNK-1:0]),
    .ci    (carry_reg),
    .sum   (slice_sum),
    .co    (slice_co),
    .c_msb (slice_c_msb)
  );

  // Slice sums enter at the top and move down, so after N slices the first
  // (least significant) slice sits at bit 0.
  if (CHUNK == WIDTH) begin : g_single
    assign res_next = slice_sum;
  end else begin : g_multi
    assign res_next = {slice_sum, res_reg[WIDTH-1:CHUNK]};
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == LAST_CNT) begin
          last_slice = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      out_sum_reg <= '0;
      out_co_reg  <= 1'b0;
      out_ovf_reg <= 1'b0;
    end else if (accept) begin
      a_reg     <= in_a;
      b_reg     <= in_sub ? ~in_b : in_b;
      // The +1 of two's-complement negation rides in on the carry.
      carry_reg <= in_sub ? 1'b1 : in_ci;
      cnt_reg   <= '0;
      res_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> CHUNK;
      b_reg     <= b_reg >> CHUNK;
      res_reg   <= res_next;
      carry_reg <= slice_co;
      cnt_reg   <= cnt_reg + 1'b1;
      if (last_slice) begin
        out_sum_reg <= res_next;
        out_co_reg  <= slice_co;
        // The last slice holds bit WIDTH-1, so its MSB carries give overflow.
        out_ovf_reg <= slice_c_msb ^ slice_co;
      end
    end
  end

  assign out_sum = out_sum_reg;
  assign out_co  = out_co_reg;
  assign out_ovf = out_ovf_reg;

`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
  // Running AND of per-slice zero tests, published with out_sum.
  logic zero_acc_reg;
  logic out_zero_reg;
  logic slice_zero;

  assign slice_zero = (slice_sum == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_acc_reg <= 1'b0;
      out_zero_reg <= 1'b0;
    end else if (accept) begin
      zero_acc_reg <= 1'b1;
    end else if (state_reg == RUN) begin
      zero_acc_reg <= zero_acc_reg & slice_zero;
      if (last_slice) begin
        out_zero_reg <= zero_acc_reg & slice_zero;
      end
    end
  end

  assign out_zero = out_zero_reg;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
// Directed testbench for seq_chunk_adder with WIDTH=32, CHUNK=8.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_ci;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_co;
  logic        out_ovf;
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  seq_chunk_adder #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ovf   (out_ovf)
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Counts edges after the accept edge until out_valid; bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic out_handshake(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check1({tag, " valid_drop"}, out_valid, 1'b0);
    check1({tag, " ready_back"}, in_ready, 1'b1);
  endtask

  // One full transaction: accept, latency, result, output handshake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sub, input logic [31:0] exp_sum,
                        input logic exp_co, input logic exp_ovf, input logic exp_zero);
    int lat;
    @(negedge clock);
    in_a      = a;
    in_b      = b;
    in_ci     = ci;
    in_sub    = sub;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check1({tag, " in_ready_idle"}, in_ready, 1'b1);
    @(posedge clock);
    #1;
    // Operands change after accept; must have no effect.
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = a ^ b;
    in_ci    = ~ci;
    in_sub   = ~sub;
    check1({tag, " in_ready_busy"}, in_ready, 1'b0);
    wait_result(lat);
    check32({tag, " latency"}, 32'(lat), 32'd4);
    check32({tag, " sum"}, out_sum, exp_sum);
    check1({tag, " co"}, out_co, exp_co);
    check1({tag, " ovf"}, out_ovf, exp_ovf);
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
    check1({tag, " zero"}, out_zero, exp_zero);
`else
    if (exp_zero && out_sum !== 32'h0) begin
      check32({tag, " zero_sum"}, out_sum, 32'h0);
    end
`endif
    $display("[TB] %s: a=%08h b=%08h ci=%b sub=%b -> sum=%08h co=%b ovf=%b lat=%0d",
             tag, a, b, ci, sub, out_sum, out_co, out_ovf, lat);
    out_handshake(tag);
  endtask

  initial begin
    int lat;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_ci     = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #1;
    check1("rst in_ready", in_ready, 1'b1);
    check1("rst out_valid", out_valid, 1'b0);
    check32("rst out_sum", out_sum, 32'h0);
    check1("rst out_co", out_co, 1'b0);
    check1("rst out_ovf", out_ovf, 1'b0);
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
    check1("rst out_zero", out_zero, 1'b0);
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed arithmetic vectors
    run_op("add_basic", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("add_wrap",  32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("sub_neg",   32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_ci_ign",32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0);
    run_op("add_ci",    32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h21436588, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held, no accept while DONE
    @(negedge clock);
    in_a = 32'd3; in_b = 32'd4; in_ci = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check32("bp latency", 32'(lat), 32'd4);
    check32("bp sum", out_sum, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      in_sub   = 1'(i);
      @(posedge clock);
      #1;
      check32("bp hold sum", out_sum, 32'd7);
      check1("bp hold valid", out_valid, 1'b1);
      check1("bp hold in_ready", in_ready, 1'b0);
    end
    $display("[TB] backpressure: held sum=%08h for 5 cycles", out_sum);
    @(negedge clock);
    in_a = 32'd100; in_b = 32'd23; in_ci = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check1("bp release valid", out_valid, 1'b0);
    check1("bp release in_ready", in_ready, 1'b1);
    check32("bp sum kept", out_sum, 32'd7);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check1("bp accept", in_ready, 1'b0);
    wait_result(lat);
    check32("bp2 latency", 32'(lat), 32'd4);
    check32("bp2 sum", out_sum, 32'd123);
    $display("[TB] post-backpressure op: 100+23 -> sum=%08h lat=%0d", out_sum, lat);
    out_handshake("bp2");

    // Reset asserted during the second RUN cycle
    @(negedge clock);
    in_a = 32'h11111111; in_b = 32'h22222222; in_ci = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check1("mid_rst out_valid", out_valid, 1'b0);
    check1("mid_rst in_ready", in_ready, 1'b1);
    check32("mid_rst out_sum", out_sum, 32'h0);
    check1("mid_rst out_co", out_co, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check1("mid_rst held valid", out_valid, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check1("mid_rst no result", out_valid, 1'b0);
    check1("mid_rst idle", in_ready, 1'b1);
    $display("[TB] reset mid-operation: aborted, out_sum=%08h", out_sum);
    run_op("post_rst", 32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
